// File: rtl/uart_rx_param_top.sv
// Parametrised UART receive channel: synchroniser, frame receiver FSM and
// receive FIFO with occupancy/threshold status and sticky error flags.
module uart_rx_param_top #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned FIFO_AW = 5
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               rx_en_i,
  input  logic               rx_i,
  input  logic [15:0]        baud_div_i,
  input  logic               parity_en_i,
  input  logic               parity_odd_i,
  input  logic               stop2_i,
  input  logic               rd_en_i,
  input  logic               clr_err_i,
  input  logic [FIFO_AW:0]   thresh_i,
  output logic [DATA_W-1:0]  rdata_o,
  output logic               rvalid_o,
  output logic [FIFO_AW:0]   count_o,
  output logic               empty_o,
  output logic               full_o,
  output logic               thresh_o,
  output logic               busy_o,
  output logic               overrun_o,
  output logic               parity_err_o,
  output logic               frame_err_o
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W = FIFO_AW + 1;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync2_q, prev_q;
  logic [15:0]         bitcnt_q, bitcnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_bad_q, par_bad_d;
  logic                stop_bad_q, stop_bad_d;
  logic                stop_idx_q, stop_idx_d;
  logic                push_q, push_d;
  logic [DATA_W-1:0]   push_data_q, push_data_d;
  logic                busy_q;

  logic                fall_c, tick_half_c, tick_bit_c;
  logic                perr_set_c, ferr_set_c;
  logic [15:0]         half_c;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [FIFO_AW-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                empty_q, full_q, thresh_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;
  logic                ovr_q, perr_q, ferr_q;
  logic                do_pop_c, do_push_c, ovr_set_c;

  // Two-flop synchroniser idling high, plus previous value for edge detect
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall_c      = prev_q & ~sync2_q;
  assign half_c      = baud_div_i >> 1;
  assign tick_half_c = (bitcnt_q + 16'd1) == half_c;
  assign tick_bit_c  = (bitcnt_q + 16'd1) == baud_div_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      par_bad_q   <= 1'b0;
      stop_bad_q  <= 1'b0;
      stop_idx_q  <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      par_bad_q   <= par_bad_d;
      stop_bad_q  <= stop_bad_d;
      stop_idx_q  <= stop_idx_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  // Receiver next state; the frame outcome is decided on the final stop sample
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q + 16'd1;
    idx_d       = idx_q;
    shift_d     = shift_q;
    par_bad_d   = par_bad_q;
    stop_bad_d  = stop_bad_q;
    stop_idx_d  = stop_idx_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    perr_set_c  = 1'b0;
    ferr_set_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        bitcnt_d = '0;
        if (rx_en_i && fall_c) begin
          state_d    = S_START;
          idx_d      = '0;
          par_bad_d  = 1'b0;
          stop_bad_d = 1'b0;
          stop_idx_d = 1'b0;
        end
      end
      S_START: begin
        if (tick_half_c) begin
          bitcnt_d = '0;
          state_d  = sync2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick_bit_c) begin
          bitcnt_d = '0;
          shift_d  = {sync2_q, shift_q[DATA_W-1:1]};
          idx_d    = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            state_d = parity_en_i ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick_bit_c) begin
          bitcnt_d  = '0;
          par_bad_d = ((^shift_q) ^ sync2_q) != parity_odd_i;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (tick_bit_c) begin
          bitcnt_d = '0;
          if (stop2_i && !stop_idx_q) begin
            stop_idx_d = 1'b1;
            stop_bad_d = stop_bad_q | ~sync2_q;
          end else begin
            state_d     = S_IDLE;
            perr_set_c  = par_bad_q;
            ferr_set_c  = stop_bad_q | ~sync2_q;
            push_d      = ~par_bad_q & ~stop_bad_q & sync2_q;
            push_data_d = shift_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Disabling the receiver abandons any partial frame
    if (state_q != S_IDLE && !rx_en_i) begin
      state_d    = S_IDLE;
      push_d     = 1'b0;
      perr_set_c = 1'b0;
      ferr_set_c = 1'b0;
    end
  end

  assign do_pop_c  = rd_en_i & ~empty_q;
  assign do_push_c = push_q & (~full_q | do_pop_c);
  assign ovr_set_c = push_q & full_q & ~do_pop_c;
  assign count_d   = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);

  always_ff @(posedge clk_i) begin
    if (do_push_c) mem_q[wptr_q] <= push_data_q;
  end

  // FIFO pointers, registered status and sticky flags (set beats clear)
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      thresh_q <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (do_push_c) wptr_q <= wptr_q + FIFO_AW'(1);
      if (do_pop_c) begin
        rptr_q  <= rptr_q + FIFO_AW'(1);
        rdata_q <= mem_q[rptr_q];
      end
      rvalid_q <= do_pop_c;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == CNT_W'(DEPTH));
      thresh_q <= (count_d >= thresh_i) && (thresh_i != '0);
      ovr_q    <= (ovr_q  & ~clr_err_i) | ovr_set_c;
      perr_q   <= (perr_q & ~clr_err_i) | perr_set_c;
      ferr_q   <= (ferr_q & ~clr_err_i) | ferr_set_c;
    end
  end

  assign rdata_o      = rdata_q;
  assign rvalid_o     = rvalid_q;
  assign count_o      = count_q;
  assign empty_o      = empty_q;
  assign full_o       = full_q;
  assign thresh_o     = thresh_q;
  assign busy_o       = busy_q;
  assign overrun_o    = ovr_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: tb/tb_uart_rx_param_top.sv
// Directed + randomized bench for uart_rx_param_top (8 data bits, 4-entry FIFO)
// against a queue-based frame model.
module tb_uart_rx_param_top;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rx_en, rx;
  logic [15:0]   baud_div;
  logic          parity_en, parity_odd, stop2;
  logic          rd_en, clr_err;
  logic [AW:0]   thresh;
  logic [DW-1:0] rdata;
  logic          rvalid, empty, full, thresh_flag, busy, ovr, perr, ferr;
  logic [AW:0]   count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mq[$];
  bit exp_ovr, exp_perr, exp_ferr;

  always #5 clk = ~clk;

  uart_rx_param_top #(.DATA_W(DW), .FIFO_AW(AW)) dut (
    .clk_i(clk), .rstn_i(rstn), .rx_en_i(rx_en), .rx_i(rx),
    .baud_div_i(baud_div), .parity_en_i(parity_en), .parity_odd_i(parity_odd),
    .stop2_i(stop2), .rd_en_i(rd_en), .clr_err_i(clr_err), .thresh_i(thresh),
    .rdata_o(rdata), .rvalid_o(rvalid), .count_o(count), .empty_o(empty),
    .full_o(full), .thresh_o(thresh_flag), .busy_o(busy), .overrun_o(ovr),
    .parity_err_o(perr), .frame_err_o(ferr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serialises one frame; optionally pulses rd_en in the push cycle or drops rx_en.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input bit pop_same, input int abort_at,
                            output bit rv_seen, output logic [7:0] rv_data,
                            output bit busy_seen);
    bit bits[$];
    int div, total, pop_at;
    div = int'(baud_div);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (parity_en) bits.push_back((^d) ^ parity_odd ^ bad_par);
    if (stop2) begin
      bits.push_back(1'b1);
      bits.push_back(~bad_stop);
    end else begin
      bits.push_back(~bad_stop);
    end
    // 2-3 clock detect, half-bit start wait, final stop sample, then push cycle
    pop_at = pop_same ? 3 + (div >> 1) + (bits.size() - 1) * div : -1;
    total = (bits.size() + 1) * div;
    rv_seen = 1'b0;
    rv_data = '0;
    busy_seen = 1'b0;
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      if (rvalid) begin
        rv_seen = 1'b1;
        rv_data = rdata;
      end
      if (i == 2 * div && busy) busy_seen = 1'b1;
      rx = (i < bits.size() * div) ? bits[i / div] : 1'b1;
      rd_en = (i == pop_at);
      if (i == abort_at) rx_en = 1'b0;
    end
    rd_en = 1'b0;
    rx = 1'b1;
  endtask

  task automatic model_rx(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    if (bad_par) exp_perr = 1'b1;
    if (bad_stop) exp_ferr = 1'b1;
    if (!bad_par && !bad_stop) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else exp_ovr = 1'b1;
    end
  endtask

  task automatic status(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(mq.size() == DEPTH));
    chk({tag, ".ovr"},   32'(ovr),   32'(exp_ovr));
    chk({tag, ".perr"},  32'(perr),  32'(exp_perr));
    chk({tag, ".ferr"},  32'(ferr),  32'(exp_ferr));
  endtask

  task automatic read_chk(input string tag);
    logic [7:0] e;
    e = mq.pop_front();
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
    chk({tag, ".rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, ".rdata"},  32'(rdata),  32'(e));
    @(negedge clk);
    chk({tag, ".rvalid_pulse"}, 32'(rvalid), 32'd0);
  endtask

  task automatic clear_errors();
    @(negedge clk) clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
    exp_ovr = 1'b0;
    exp_perr = 1'b0;
    exp_ferr = 1'b0;
  endtask

  task automatic rx_word(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    bit rv, bz;
    logic [7:0] rvd;
    send_frame(d, bad_par, bad_stop, 1'b0, -1, rv, rvd, bz);
    model_rx(d, bad_par, bad_stop);
  endtask

  initial begin
    bit rv, bz;
    logic [7:0] rvd, d, head;
    rstn = 1'b0; rx_en = 1'b1; rx = 1'b1; baud_div = 16'd16;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    rd_en = 1'b0; clr_err = 1'b0; thresh = '0;
    exp_ovr = 0; exp_perr = 0; exp_ferr = 0;
    tick(3);
    rstn = 1'b1;
    tick(2);
    chk("reset.rdata", 32'(rdata), 32'd0);
    chk("reset.rvalid", 32'(rvalid), 32'd0);
    chk("reset.thresh", 32'(thresh_flag), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    status("reset");

    // Basic 8N1 frame
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, -1, rv, rvd, bz);
    model_rx(8'hA5, 1'b0, 1'b0);
    chk("basic.busy_mid", 32'(bz), 32'd1);
    status("basic");
    read_chk("basic.read");
    status("basic_after_read");

    // Odd parity: good, bad, then two stop bits with second low
    parity_en = 1'b1; parity_odd = 1'b1;
    rx_word(8'h3C, 1'b0, 1'b0);
    status("par_good");
    rx_word(8'h3C, 1'b1, 1'b0);
    status("par_bad");
    stop2 = 1'b1;
    rx_word(8'h3C, 1'b0, 1'b1);
    status("stop2_bad");
    read_chk("par.read");
    clear_errors();
    tick(1);
    status("par_clr");
    parity_en = 1'b0; stop2 = 1'b0;

    // Overrun
    for (int i = 1; i <= 5; i++) rx_word(8'(i), 1'b0, 1'b0);
    status("overrun");
    for (int i = 0; i < 4; i++) read_chk("overrun.read");
    clear_errors();
    tick(1);
    status("overrun_clr");

    // Pop in push cycle when full, then when empty
    for (int i = 0; i < 4; i++) rx_word(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    d = 8'($urandom_range(0, 255));
    send_frame(d, 1'b0, 1'b0, 1'b1, -1, rv, rvd, bz);
    head = mq.pop_front();
    model_rx(d, 1'b0, 1'b0);
    chk("full_pp.rvalid_seen", 32'(rv), 32'd1);
    chk("full_pp.rdata", 32'(rvd), 32'(head));
    status("full_pp");
    for (int i = 0; i < 4; i++) read_chk("full_pp.read");
    d = 8'($urandom_range(0, 255));
    send_frame(d, 1'b0, 1'b0, 1'b1, -1, rv, rvd, bz);
    model_rx(d, 1'b0, 1'b0);
    chk("empty_pp.rvalid_seen", 32'(rv), 32'd0);
    status("empty_pp");
    read_chk("empty_pp.read");

    // Abort at data bit 3
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 4 * 16, rv, rvd, bz);
    chk("abort.busy_mid", 32'(bz), 32'd1);
    chk("abort.busy", 32'(busy), 32'd0);
    status("abort");
    rx_en = 1'b1;
    tick(2);

    // Three-clock glitch is a false start
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(40);
    chk("glitch.busy", 32'(busy), 32'd0);
    status("glitch");

    // Reset in the middle of a frame with three words stored
    for (int i = 0; i < 3; i++) rx_word(8'($urandom_range(1, 255)), 1'b0, 1'b0);
    read_chk("prereset.read");
    rx_word(8'hC3, 1'b0, 1'b0);
    @(negedge clk) rx = 1'b0;
    tick(40);
    chk("prereset.busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    mq.delete();
    chk("midreset.rdata", 32'(rdata), 32'd0);
    chk("midreset.rvalid", 32'(rvalid), 32'd0);
    chk("midreset.busy", 32'(busy), 32'd0);
    chk("midreset.thresh", 32'(thresh_flag), 32'd0);
    status("midreset");
    tick(3);
    rx = 1'b1;
    rstn = 1'b1;
    tick(3);
    status("postreset");

    // Threshold then 40 randomized push/pop pairs across pointer wrap
    thresh = 3'd3;
    tick(1);
    for (int i = 0; i < 2; i++) rx_word(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    chk("thresh.below", 32'(thresh_flag), 32'd0);
    rx_word(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    chk("thresh.at", 32'(thresh_flag), 32'd1);
    for (int i = 0; i < 40; i++) begin
      baud_div = 16'($urandom_range(8, 24));
      parity_en = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      stop2 = 1'($urandom_range(0, 1));
      rx_word(8'($urandom_range(0, 255)), 1'b0, 1'b0);
      chk("wrap.count_full", 32'(count), 32'(mq.size()));
      read_chk("wrap.read");
    end
    chk("wrap.thresh", 32'(thresh_flag), 32'd1);
    status("wrap_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
